rtc_bus_sequencer: RTL

RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

---
 rtl/rtc_pkg.sv | 50 +++++
 rtl/rtc_bus_sequencer_if.sv | 43 ++++
 rtl/rtc_phase_timer.sv | 40 ++++
 rtl/rtc_bus_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Shared definitions for the RTC bus sequencer. Holds the
//               transaction state enumeration, the read-slot indices and the
//               nine-entry table that maps each slot to its RTC register
//               address.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_GAP   = 3'd2,
    ST_DATA  = 3'd3,
    ST_RECOV = 3'd4
  } rtc_state_e;

  // Read-sweep slot indices (also the value presented on rd_index)
  localparam logic [3:0] SLOT_HOURS  = 4'd0;
  localparam logic [3:0] SLOT_MIN    = 4'd1;
  localparam logic [3:0] SLOT_SEC    = 4'd2;
  localparam logic [3:0] SLOT_MONTH  = 4'd3;
  localparam logic [3:0] SLOT_DAY    = 4'd4;
  localparam logic [3:0] SLOT_YEAR   = 4'd5;
  localparam logic [3:0] SLOT_THOURS = 4'd6;
  localparam logic [3:0] SLOT_TMIN   = 4'd7;
  localparam logic [3:0] SLOT_TSEC   = 4'd8;
  localparam int         NUM_SLOTS   = 9;

  // RTC register address for each read slot
  function automatic logic [7:0] rtc_addr(input logic [3:0] slot);
    case (slot)
      SLOT_HOURS:  rtc_addr = 8'h23;
      SLOT_MIN:    rtc_addr = 8'h22;
      SLOT_SEC:    rtc_addr = 8'h21;
      SLOT_MONTH:  rtc_addr = 8'h25;
      SLOT_DAY:    rtc_addr = 8'h24;
      SLOT_YEAR:   rtc_addr = 8'h26;
      SLOT_THOURS: rtc_addr = 8'h43;
      SLOT_TMIN:   rtc_addr = 8'h42;
      SLOT_TSEC:   rtc_addr = 8'h41;
      default:     rtc_addr = 8'h23;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_sequencer_if
// Description : User-side handshake and RTC multiplexed-bus signals of the
//               sequencer.
// Ports       : master - sequencer side (drives strobes, ad_out, read results,
//                        wr_ack); slave - user/RTC side (drives wr_req,
//                        wr_addr, wr_data, ad_in).
// Revision    : 1.0 - initial release
// ============================================================================
interface rtc_bus_sequencer_if;

  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic [7:0] rd_data;
  logic [3:0] rd_index;
  logic       rd_valid;
  logic       w_r;
  logic       busy;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ale;

  modport master (
    input  wr_req, wr_addr, wr_data, ad_in,
    output wr_ack, rd_data, rd_index, rd_valid, w_r, busy,
    output ad_out, ad_oe, cs_n, rd_n, wr_n, ale
  );

  modport slave (
    output wr_req, wr_addr, wr_data, ad_in,
    input  wr_ack, rd_data, rd_index, rd_valid, w_r, busy,
    input  ad_out, ad_oe, cs_n, rd_n, wr_n, ale
  );

endinterface
`default_nettype wire

// File: rtl/rtc_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : rtc_phase_timer
// Description : Down-counter timing one bus phase. load_i restarts the phase,
//               done_o is high on the last cycle of the phase.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               load_i     - start a new phase of PHASE_CYC cycles
//               count_i    - advance the counter
//               done_o     - current cycle is the last of the phase
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_phase_timer #(
  parameter int PHASE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic count_i,
  output logic done_o
);

  // Loading PHASE_CYC-1 makes the phase span exactly PHASE_CYC cycles
  localparam logic [3:0] LOAD_VAL = 4'(PHASE_CYC - 1);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (count_i && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done_o = (cnt_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_sequencer
// Description : Sequences write and periodic read-sweep transactions onto a
//               multiplexed address/data RTC bus. Every transaction walks
//               ADDR -> GAP -> DATA -> RECOV, each phase PHASE_CYC cycles.
//               A refresh counter triggers a nine-register read sweep every
//               REFRESH_CYC cycles; user writes take priority and are slotted
//               between sweep reads.
// Ports       : clk, rst - clock, synchronous active-high reset
//               bus      - master modport: write handshake, read results,
//                          status (w_r, busy) and RTC bus strobes/data
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_sequencer
  import rtc_pkg::*;
#(
  parameter int PHASE_CYC   = 4,
  parameter int REFRESH_CYC = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  rtc_bus_sequencer_if.master  bus
);

  localparam int             RW           = $clog2(REFRESH_CYC);
  localparam logic [RW-1:0]  REFRESH_LAST = RW'(REFRESH_CYC - 1);
  localparam logic [3:0]     LAST_SLOT    = 4'(NUM_SLOTS - 1);

  rtc_state_e    state_q;
  logic [RW-1:0] refresh_q;
  logic [RW-1:0] refresh_d;
  logic          sweep_act_q;
  logic [3:0]    sweep_idx_q;
  logic          wr_block_q;
  logic [7:0]    data_q;

  logic          cs_n_q;
  logic          rd_n_q;
  logic          wr_n_q;
  logic          ale_q;
  logic          ad_oe_q;
  logic [7:0]    ad_out_q;
  logic          wr_ack_q;
  logic          rd_valid_q;
  logic [7:0]    rd_data_q;
  logic [3:0]    rd_index_q;
  logic          w_r_q;
  logic          busy_q;

  logic          w_expire;
  logic          w_wr_go;
  logic          w_start;
  logic          w_load;
  logic          w_count;
  logic          w_done;

  // --------------------------------------------------------------------------
  // Refresh counter: free-running, wraps on expiry
  // --------------------------------------------------------------------------
  assign w_expire  = (refresh_q == REFRESH_LAST);
  assign refresh_d = w_expire ? '0 : refresh_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
    end else begin
      refresh_q <= refresh_d;
    end
  end

  // --------------------------------------------------------------------------
  // Phase timer control. It is reloaded on every phase change so each
  // non-idle state lasts exactly PHASE_CYC cycles.
  // --------------------------------------------------------------------------
  // A write held high after its ack is blocked until wr_req is seen low
  assign w_wr_go = bus.wr_req && !wr_block_q;
  assign w_start = (state_q == ST_IDLE) && (w_wr_go || sweep_act_q);
  assign w_count = (state_q != ST_IDLE);
  assign w_load  = w_start || (w_count && w_done);

  rtc_phase_timer #(
    .PHASE_CYC (PHASE_CYC)
  ) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_load),
    .count_i (w_count),
    .done_o  (w_done)
  );

  // --------------------------------------------------------------------------
  // Transaction FSM with registered bus outputs. Outputs are set on the edge
  // that enters each state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      ale_q       <= 1'b0;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= 8'h00;
      wr_ack_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 8'h00;
      rd_index_q  <= 4'd0;
      w_r_q       <= 1'b1;
      busy_q      <= 1'b0;
      sweep_act_q <= 1'b0;
      sweep_idx_q <= 4'd0;
      wr_block_q  <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;

      if (!bus.wr_req) begin
        wr_block_q <= 1'b0;
      end

      // Expiry while a sweep is running is dropped, never queued
      if (w_expire && !sweep_act_q) begin
        sweep_act_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (w_start) begin
            state_q <= ST_ADDR;
            busy_q  <= 1'b1;
            ale_q   <= 1'b1;
            ad_oe_q <= 1'b1;
            cs_n_q  <= 1'b0;
            wr_n_q  <= 1'b0;
            rd_n_q  <= 1'b1;
            // Writes win arbitration over the next sweep read
            if (w_wr_go) begin
              w_r_q    <= 1'b0;
              ad_out_q <= bus.wr_addr;
              data_q   <= bus.wr_data;
            end else begin
              w_r_q    <= 1'b1;
              ad_out_q <= rtc_addr(sweep_idx_q);
            end
          end
        end

        ST_ADDR: begin
          if (w_done) begin
            state_q <= ST_GAP;
            ale_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
          end
        end

        ST_GAP: begin
          if (w_done) begin
            state_q <= ST_DATA;
            cs_n_q  <= 1'b0;
            if (w_r_q) begin
              rd_n_q  <= 1'b0;
              wr_n_q  <= 1'b1;
              ad_oe_q <= 1'b0;
            end else begin
              rd_n_q   <= 1'b1;
              wr_n_q   <= 1'b0;
              ad_oe_q  <= 1'b1;
              ad_out_q <= data_q;
            end
          end
        end

        ST_DATA: begin
          if (w_done) begin
            state_q <= ST_RECOV;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            ad_oe_q <= 1'b0;
            // ad_in is sampled on the last DATA cycle
            if (w_r_q) begin
              rd_data_q  <= bus.ad_in;
              rd_index_q <= sweep_idx_q;
              rd_valid_q <= 1'b1;
            end
          end
        end

        ST_RECOV: begin
          if (w_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (!w_r_q) begin
              wr_ack_q   <= 1'b1;
              wr_block_q <= 1'b1;
            end else if (sweep_idx_q == LAST_SLOT) begin
              sweep_act_q <= 1'b0;
              sweep_idx_q <= 4'd0;
            end else begin
              sweep_idx_q <= sweep_idx_q + 4'd1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cs_n     = cs_n_q;
  assign bus.rd_n     = rd_n_q;
  assign bus.wr_n     = wr_n_q;
  assign bus.ale      = ale_q;
  assign bus.ad_oe    = ad_oe_q;
  assign bus.ad_out   = ad_out_q;
  assign bus.wr_ack   = wr_ack_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_index = rd_index_q;
  assign bus.w_r      = w_r_q;
  assign bus.busy     = busy_q;

endmodule
`default_nettype wire
